quick_spi_slave: RTL and testbench

SPI responder (slave) for the team's SPI master. Oversamples sclk, ss_n and mosi on the system clock, deserialises one RX word per frame and serialises one TX word on miso. Sits at a peripheral/loopback end; presents parallel words through a valid/ready-style interface to local logic.

---
 rtl/quick_spi_pkg.sv | 30 +++
 rtl/quick_spi_sync_edge.sv | 39 +++
 rtl/quick_spi_slave.sv | 212 +++++++++++++++++++++
 tb/tb_quick_spi_slave.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/quick_spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// quick_spi_pkg : shared types, SPI mode constants and wire-order mapping
// Rev 1.0
// ---------------------------------------------------------------------------
package quick_spi_pkg;

  typedef enum logic [1:0] {
    WAIT_DESEL = 2'd0,
    IDLE       = 2'd1,
    ACTIVE     = 2'd2
  } spi_state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int unsigned c_CNT_W = 7;

  // Most-significant byte first on the wire, LSB first within each byte.
  function automatic int unsigned stream_to_word_bit(input int unsigned i,
                                                     input int unsigned width);
    return (width / 8 - 1 - i / 8) * 8 + i % 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quick_spi_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// quick_spi_sync_edge : 2-FF synchroniser with registered rise/fall detection
// Rev 1.0
// ---------------------------------------------------------------------------
module quick_spi_sync_edge #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/quick_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// quick_spi_slave : oversampled SPI responder, one RX and one TX word per frame
// Rev 1.0
// ---------------------------------------------------------------------------
module quick_spi_slave
  import quick_spi_pkg::*;
#(
  parameter int unsigned RX_WIDTH = 16,
  parameter int unsigned TX_WIDTH = 8,
  parameter bit          CPOL     = 1'b0,
  parameter bit          CPHA     = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                ss_n,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  output logic                rx_error,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_underrun,
  output logic                busy
);

  localparam int unsigned        c_RX_IW   = $clog2(RX_WIDTH);
  localparam int unsigned        c_TX_IW   = $clog2(TX_WIDTH);
  localparam logic [c_CNT_W-1:0] c_RX_MAX  = c_CNT_W'(RX_WIDTH);
  localparam logic [c_CNT_W-1:0] c_TX_MAX  = c_CNT_W'(TX_WIDTH);
  localparam int unsigned        c_TX_BIT0 = TX_WIDTH - 8;
  localparam logic [1:0]         c_MODE    = {CPOL, CPHA};

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_ss_lvl, w_ss_rise, w_ss_fall;
  logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall, w_unused_sclk_lvl;

  quick_spi_sync_edge #(.RESET_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst(reset), .i_async(sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  // Select resets to "asserted" so a frame already in progress is never seen as a fresh fall.
  quick_spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_ss (
    .clk(clk), .rst(reset), .i_async(ss_n),
    .o_level(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  quick_spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(reset), .i_async(mosi),
    .o_level(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  assign w_unused_sclk_lvl = w_sclk_lvl;

  logic w_lead_edge, w_trail_edge, w_sample_edge, w_shift_edge;
  assign w_lead_edge   = CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail_edge  = CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_sample_edge = (c_MODE == MODE0 || c_MODE == MODE2) ? w_lead_edge : w_trail_edge;
  assign w_shift_edge  = (c_MODE == MODE0 || c_MODE == MODE2) ? w_trail_edge : w_lead_edge;

  spi_state_t            r_state, w_state_next;
  logic [RX_WIDTH-1:0]   r_rx_shift, w_rx_shift_next;
  logic [RX_WIDTH-1:0]   r_rx_data, w_rx_data_next;
  logic [c_CNT_W-1:0]    r_rx_cnt, w_rx_cnt_next;
  logic [TX_WIDTH-1:0]   r_tx_shift, w_tx_shift_next;
  logic [c_CNT_W-1:0]    r_tx_cnt, w_tx_cnt_next;
  logic [TX_WIDTH-1:0]   r_hold, w_hold_next;
  logic                  r_hold_full, w_hold_full_next;
  logic                  r_miso, w_miso_next;
  logic                  r_miso_oe, w_miso_oe_next;
  logic                  r_busy, w_busy_next;
  logic                  r_rx_valid, w_rx_valid_next;
  logic                  r_rx_error, w_rx_error_next;
  logic                  r_tx_underrun, w_tx_underrun_next;
  logic                  w_load;
  logic [c_RX_IW-1:0]    w_rx_idx;
  logic [c_TX_IW-1:0]    w_tx_idx;

  assign w_load   = tx_valid & ~r_hold_full;
  assign w_rx_idx = c_RX_IW'(stream_to_word_bit(32'(r_rx_cnt), RX_WIDTH));
  assign w_tx_idx = c_TX_IW'(stream_to_word_bit(32'(r_tx_cnt), TX_WIDTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= WAIT_DESEL;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_cnt      <= '0;
      r_tx_shift    <= '0;
      r_tx_cnt      <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_busy        <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_rx_error    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_rx_shift    <= w_rx_shift_next;
      r_rx_data     <= w_rx_data_next;
      r_rx_cnt      <= w_rx_cnt_next;
      r_tx_shift    <= w_tx_shift_next;
      r_tx_cnt      <= w_tx_cnt_next;
      r_hold        <= w_hold_next;
      r_hold_full   <= w_hold_full_next;
      r_miso        <= w_miso_next;
      r_miso_oe     <= w_miso_oe_next;
      r_busy        <= w_busy_next;
      r_rx_valid    <= w_rx_valid_next;
      r_rx_error    <= w_rx_error_next;
      r_tx_underrun <= w_tx_underrun_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_rx_shift_next    = r_rx_shift;
    w_rx_data_next     = r_rx_data;
    w_rx_cnt_next      = r_rx_cnt;
    w_tx_shift_next    = r_tx_shift;
    w_tx_cnt_next      = r_tx_cnt;
    w_hold_next        = r_hold;
    w_hold_full_next   = r_hold_full;
    w_miso_next        = r_miso;
    w_miso_oe_next     = r_miso_oe;
    w_busy_next        = r_busy;
    w_rx_valid_next    = 1'b0;
    w_rx_error_next    = 1'b0;
    w_tx_underrun_next = 1'b0;

    if (w_load) begin
      w_hold_next      = tx_data;
      w_hold_full_next = 1'b1;
    end

    case (r_state)
      WAIT_DESEL: begin
        if (w_ss_lvl) w_state_next = IDLE;
      end

      IDLE: begin
        if (w_ss_fall) begin
          // The frame takes the pre-load holding contents; a same-cycle load survives.
          w_state_next       = ACTIVE;
          w_busy_next        = 1'b1;
          w_miso_oe_next     = 1'b1;
          w_rx_cnt_next      = '0;
          w_rx_shift_next    = '0;
          w_tx_shift_next    = r_hold_full ? r_hold : '0;
          w_tx_underrun_next = ~r_hold_full;
          if (!w_load) w_hold_full_next = 1'b0;
          if (!CPHA) begin
            w_miso_next   = r_hold_full & r_hold[c_TX_BIT0];
            w_tx_cnt_next = c_CNT_W'(1);
          end else begin
            w_miso_next   = 1'b0;
            w_tx_cnt_next = '0;
          end
        end
      end

      ACTIVE: begin
        if (w_ss_rise) begin
          w_rx_error_next = (r_rx_cnt < c_RX_MAX);
          w_busy_next     = 1'b0;
          w_miso_oe_next  = 1'b0;
          w_miso_next     = 1'b0;
          w_state_next    = IDLE;
        end else begin
          if (w_sample_edge && (r_rx_cnt < c_RX_MAX)) begin
            w_rx_shift_next[w_rx_idx] = w_mosi;
            w_rx_cnt_next             = r_rx_cnt + c_CNT_W'(1);
            if (r_rx_cnt == c_RX_MAX - c_CNT_W'(1)) begin
              w_rx_data_next  = w_rx_shift_next;
              w_rx_valid_next = 1'b1;
            end
          end
          // r_tx_cnt counts bits already driven; past the word miso idles low.
          if (w_shift_edge) begin
            if (r_tx_cnt < c_TX_MAX) begin
              w_miso_next   = r_tx_shift[w_tx_idx];
              w_tx_cnt_next = r_tx_cnt + c_CNT_W'(1);
            end else begin
              w_miso_next = 1'b0;
            end
          end
        end
      end

      default: w_state_next = WAIT_DESEL;
    endcase
  end

  assign miso        = r_miso;
  assign miso_oe     = r_miso_oe;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_error    = r_rx_error;
  assign tx_ready    = ~r_hold_full;
  assign tx_underrun = r_tx_underrun;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_quick_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_quick_spi_slave : one responder per SPI mode driven by a behavioural master
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_quick_spi_slave;

  localparam int K_UND = 1;
  localparam int K_RXV = 2;
  localparam int K_RXE = 3;

  typedef struct {
    int          mode;
    int          kind;
    logic [15:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic sclk[4], ss_n[4], mosi[4], tx_valid[4];
  logic [7:0] tx_data[4];
  logic miso[4], miso_oe[4], rx_valid[4], rx_error[4], tx_ready[4], tx_underrun[4], busy[4];
  logic [15:0] rx_data[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    quick_spi_slave #(
      .RX_WIDTH(16), .TX_WIDTH(8), .CPOL(1'(g / 2)), .CPHA(1'(g % 2))
    ) u_dut (
      .clk(clk), .reset(reset), .sclk(sclk[g]), .ss_n(ss_n[g]), .mosi(mosi[g]),
      .miso(miso[g]), .miso_oe(miso_oe[g]), .rx_data(rx_data[g]),
      .rx_valid(rx_valid[g]), .rx_error(rx_error[g]), .tx_data(tx_data[g]),
      .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]), .tx_underrun(tx_underrun[g]),
      .busy(busy[g])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;
  ev_t exp_q[$];

  // Reference state: holding register and last good word, per responder.
  logic        hold_full[4];
  logic [7:0]  hold[4];
  logic [15:0] last_rx[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic got_event(input int m, input int kind, input logic [15:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got mode %0d kind %0d data %h expected none", m, kind, data);
    end else begin
      e = exp_q.pop_front();
      check("event", {32'(m), 8'(kind), 8'h0, data}, {32'(e.mode), 8'(e.kind), 8'h0, e.data});
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (tx_underrun[m] === 1'b1) got_event(m, K_UND, 16'h0);
      if (rx_valid[m] === 1'b1)    got_event(m, K_RXV, rx_data[m]);
      if (rx_error[m] === 1'b1)    got_event(m, K_RXE, 16'h0);
    end
  end

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      hold_full[m] = 1'b0;
      hold[m]      = 8'h0;
      last_rx[m]   = 16'h0;
    end
  endtask

  task automatic load_tx(input int m, input logic [7:0] w);
    tx_data[m]  = w;
    tx_valid[m] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_full[m]) begin
      hold[m]      = w;
      hold_full[m] = 1'b1;
    end
    tx_valid[m] = 1'b0;
    #1;
  endtask

  // Master frame: nbits of word (MS byte first, LSB first per byte), then extra clocks.
  task automatic do_frame(input int m, input logic [15:0] word, input int nbits,
                          input int extra, input bit conc, input logic [7:0] conc_word);
    bit          cpol, cpha, loaded;
    int          total;
    logic        b;
    logic [7:0]  frame_tx;
    logic        mbits[$];
    logic        tbits[$];
    logic [31:0] cap, expv;

    cpol  = (m / 2) == 1;
    cpha  = (m % 2) == 1;
    total = nbits + extra;
    cap   = '0;
    expv  = '0;

    check("tx_ready_before", 64'(tx_ready[m]), 64'(!hold_full[m]));
    if (!hold_full[m]) exp_q.push_back('{m, K_UND, 16'h0});
    frame_tx = hold_full[m] ? hold[m] : 8'h0;
    loaded   = conc && !hold_full[m];
    hold_full[m] = loaded;
    if (loaded) hold[m] = conc_word;
    if (nbits >= 16) begin
      exp_q.push_back('{m, K_RXV, word});
      last_rx[m] = word;
    end else begin
      exp_q.push_back('{m, K_RXE, 16'h0});
    end

    for (int by = 1; by >= 0; by--)
      for (int k = 0; k < 8; k++) mbits.push_back(word[by*8+k]);
    for (int k = 0; k < 8; k++) tbits.push_back(frame_tx[k]);
    for (int i = 0; i < total; i++) expv[i] = (i < 8) ? tbits[i] : 1'b0;

    ss_n[m] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    if (conc) begin
      tx_data[m]  = conc_word;
      tx_valid[m] = 1'b1;
    end
    @(posedge clk);
    #2;
    tx_valid[m] = 1'b0;
    check("tx_ready_at_start", 64'(tx_ready[m]), 64'(!hold_full[m]));
    check("busy_oe_at_start", {62'h0, busy[m], miso_oe[m]}, 64'h3);
    #48;

    for (int i = 0; i < total; i++) begin
      b = (i < nbits) ? mbits[i] : 1'($urandom_range(0, 1));
      if (!cpha) begin
        mosi[m] = b;
        #80;
        cap[i]  = miso[m];
        sclk[m] = ~cpol;
        #80;
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = b;
        #80;
        cap[i]  = miso[m];
        sclk[m] = cpol;
        #80;
      end
    end
    #80;
    ss_n[m] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("busy_oe_after_deselect", {62'h0, busy[m], miso_oe[m]}, 64'h0);
    check("miso_stream", 64'(cap), 64'(expv));
    check("rx_data_after_frame", 64'(rx_data[m]), 64'(last_rx[m]));
    #60;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          nb;
    reset = 1'b1;
    for (int m = 0; m < 4; m++) begin
      sclk[m] = 1'((m / 2) == 1); ss_n[m] = 1'b1; mosi[m] = 1'b0;
      tx_valid[m] = 1'b0; tx_data[m] = 8'h0;
    end
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    for (int m = 0; m < 4; m++)
      check("reset_values", {41'h0, miso[m], miso_oe[m], rx_valid[m], rx_error[m],
            tx_ready[m], tx_underrun[m], busy[m], rx_data[m]},
            {41'h0, 7'b0000100, 16'h0});
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #2;

    // Basic mode-0 frame, then overclocked frame, then short frame.
    load_tx(0, 8'hA5);
    do_frame(0, 16'h1234, 16, 0, 1'b0, 8'h0);
    load_tx(0, 8'hA5);
    do_frame(0, 16'h1234, 16, 3, 1'b0, 8'h0);
    load_tx(0, 8'h5A);
    do_frame(0, 16'hBEEF, 9, 0, 1'b0, 8'h0);

    // Underrun with a load landing in the frame-start cycle, then that word sent.
    do_frame(0, 16'h5A5A, 16, 0, 1'b1, 8'h3C);
    do_frame(0, 16'h0F0F, 16, 0, 1'b0, 8'h0);

    for (int m = 0; m < 4; m++) begin
      load_tx(m, 8'($urandom));
      do_frame(m, 16'hC3F0, 16, 0, 1'b0, 8'h0);
    end

    for (int it = 0; it < 14; it++) begin
      int m;
      m  = int'($urandom_range(0, 3));
      w  = 16'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      if ($urandom_range(0, 1) == 1) load_tx(m, 8'($urandom));
      do_frame(m, w, nb, (nb == 16) ? int'($urandom_range(0, 3)) : 0,
               1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Reset in the middle of a frame with select held low.
    load_tx(0, 8'h99);
    hold_full[0] = 1'b0;
    ss_n[0] = 1'b0;
    #80;
    for (int i = 0; i < 5; i++) begin
      mosi[0] = 1'($urandom_range(0, 1)); #80; sclk[0] = 1'b1; #80; sclk[0] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("busy_rxdata_after_reset", {47'h0, busy[0], rx_data[0]}, 64'h0);
    for (int i = 0; i < 8; i++) begin
      mosi[0] = 1'($urandom_range(0, 1)); #80; sclk[0] = 1'b1; #80; sclk[0] = 1'b0;
    end
    #80;
    check("ignored_while_selected", {62'h0, busy[0], miso_oe[0]}, 64'h0);
    ss_n[0] = 1'b1;
    #200;
    do_frame(0, 16'h6C93, 16, 0, 1'b0, 8'h0);

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
